// File: rtl/dti_fifo_pkg.sv
// rtl/dti_fifo_pkg.sv - shared constants for the async FIFO blocks
package dti_fifo_pkg;

    // Synchronizer depth used by every async FIFO block unless overridden.
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Fewer flops than this does not give a usable MTBF.
    localparam int SYNC_STAGES_MIN = 2;

endpackage : dti_fifo_pkg

// File: rtl/dti_gray_to_bin.sv
// rtl/dti_gray_to_bin.sv - combinational gray to binary converter
module dti_gray_to_bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Bit i is the XOR of all gray bits from the MSB down to i.
    always_comb begin
        bin = '0;
        bin[WIDTH-1] = gray[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
    end

endmodule : dti_gray_to_bin

// File: rtl/dti_sync_bus.sv
// rtl/dti_sync_bus.sv - per-bit flop-chain synchronizer for a gray-coded bus
module dti_sync_bus
    import dti_fifo_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_data,
    output logic [WIDTH-1:0] sync_data
);

    // A request below the minimum depth is raised to the minimum.
    localparam int NSTAGE = (STAGES < SYNC_STAGES_MIN) ? SYNC_STAGES_MIN : STAGES;

    logic [WIDTH-1:0] stage_q [NSTAGE];

    // Plain shift chain: each stage copies the previous one, nothing in between.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NSTAGE; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_data;
            for (int i = 1; i < NSTAGE; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_data = stage_q[NSTAGE-1];

endmodule : dti_sync_bus

// File: rtl/dti_fifo_async_ptr.sv
// rtl/dti_fifo_async_ptr.sv - local gray/binary pointer plus remote pointer synchronizer
module dti_fifo_async_ptr
    import dti_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                incr_ptr,
    input  logic [ADDR_WIDTH:0] gray_remote_ptr,
    output logic [ADDR_WIDTH:0] bin_local_ptr,
    output logic [ADDR_WIDTH:0] gray_local_ptr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [ADDR_WIDTH:0] gray_synced_ptr,
    output logic [ADDR_WIDTH:0] bin_synced_ptr,
    output logic                ptr_update
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] bin_q;
    logic [PW-1:0] gray_q;
    logic [PW-1:0] bin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] synced_prev_q;
    logic          ptr_update_q;

    // Next pointer values; gray is derived from the next binary so both flops
    // update on the same edge and the exported gray has no combinational path.
    always_comb begin
        bin_next  = bin_q + {{ADDR_WIDTH{1'b0}}, incr_ptr};
        gray_next = bin_next ^ (bin_next >> 1);
    end

    // Local pointer registers; the MSB is the lap bit, wrap is natural overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bin_q  <= '0;
            gray_q <= '0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
        end
    end

    dti_sync_bus #(
        .WIDTH  (PW),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset_n    (reset_n),
        .async_data (gray_remote_ptr),
        .sync_data  (gray_synced_ptr)
    );

    dti_gray_to_bin #(
        .WIDTH (PW)
    ) u_g2b (
        .gray (gray_synced_ptr),
        .bin  (bin_synced_ptr)
    );

    // Change detector: one-cycle pulse the cycle after the synced pointer moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            synced_prev_q <= '0;
            ptr_update_q  <= 1'b0;
        end else begin
            synced_prev_q <= gray_synced_ptr;
            ptr_update_q  <= (gray_synced_ptr != synced_prev_q);
        end
    end

    assign bin_local_ptr  = bin_q;
    assign gray_local_ptr = gray_q;
    assign mem_addr       = bin_q[ADDR_WIDTH-1:0];
    assign ptr_update     = ptr_update_q;

endmodule : dti_fifo_async_ptr
